// File: rtl/timer_compare_pkg.sv
// Shared types and default widths for the timer_compare block.
package timer_compare_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int EXT_W_DEF = 8;

endpackage

// File: rtl/count_seq_monitor.sv
// Watches the upstream count/overflow stream and latches a sticky error on any
// step that is not hold, +1 or return-to-zero, or on an overflow away from all-ones.
module count_seq_monitor
    import timer_compare_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_i,
    input  logic             overflow_i,
    output logic             seq_err
);

    logic [CNT_W-1:0] prev_q;
    logic             prev_valid;
    logic [CNT_W-1:0] prev_inc;
    logic             step_ok;
    logic             ovf_bad;

    assign prev_inc = prev_q + 1'b1;
    // Zero is always accepted: the upstream counter may have been reset.
    assign step_ok  = (count_i == prev_q) || (count_i == prev_inc) || (count_i == '0);
    assign ovf_bad  = overflow_i && !(&count_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            prev_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prev_q     <= count_i;
            prev_valid <= 1'b1;
            if ((prev_valid && !step_ok) || ovf_bad)
                seq_err <= 1'b1;
        end
    end

endmodule

// File: rtl/timer_compare.sv
// Extends an upstream counter into a timestamp and provides a one-shot compare alarm.
// Define TIMER_CMP_AUTO_REARM_EN to add period_i and periodic re-arming on acknowledge.
module timer_compare
    import timer_compare_pkg::*;
#(
    parameter  int CNT_W = CNT_W_DEF,
    parameter  int EXT_W = EXT_W_DEF,
    localparam int TS_W  = CNT_W + EXT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CNT_W-1:0] count_i,
    input  logic            overflow_i,
    input  logic            cmp_wr,
    input  logic [TS_W-1:0] cmp_data,
    input  logic            arm,
    input  logic            disarm,
    input  logic            irq_ack,
`ifdef TIMER_CMP_AUTO_REARM_EN
    input  logic [TS_W-1:0] period_i,
`endif
    output logic [TS_W-1:0] timestamp,
    output logic            irq,
    output logic [1:0]      state_o,
    output logic            ext_ovf,
    output logic            seq_err
);

    logic [EXT_W-1:0] ext_q;
    logic [TS_W-1:0]  cmp_q;
    state_t           state;
    logic             match;

    // ext_q bumps on the overflow edge, so the following count=0 already sees it.
    assign timestamp = {ext_q, count_i};
    assign match     = (timestamp == cmp_q);
    assign state_o   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q   <= '0;
            ext_ovf <= 1'b0;
            cmp_q   <= '0;
            state   <= IDLE;
            irq     <= 1'b0;
        end else begin
            if (overflow_i) begin
                ext_q <= ext_q + 1'b1;
                if (&ext_q)
                    ext_ovf <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmp_wr)
                        cmp_q <= cmp_data;
                    if (arm)
                        state <= ARMED;
                end
                ARMED: begin
                    if (disarm) begin
                        state <= IDLE;
                    end else if (match) begin
                        state <= FIRED;
                        irq   <= 1'b1;
                    end
                end
                FIRED: begin
                    if (irq_ack) begin
                        irq <= 1'b0;
`ifdef TIMER_CMP_AUTO_REARM_EN
                        if (disarm) begin
                            state <= IDLE;
                        end else begin
                            cmp_q <= cmp_q + period_i;
                            state <= ARMED;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    count_seq_monitor #(
        .CNT_W(CNT_W)
    ) u_seq_mon (
        .clk       (clk),
        .rst       (rst),
        .count_i   (count_i),
        .overflow_i(overflow_i),
        .seq_err   (seq_err)
    );

endmodule

// File: tb/tb_timer_compare.sv
// Directed bench for timer_compare: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_timer_compare;

    localparam int SEL_TS = 0, SEL_IRQ = 1, SEL_ST = 2, SEL_EOVF = 3, SEL_SERR = 4;

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] v;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  count_i;
    logic        overflow_i;
    logic        cmp_wr;
    logic [15:0] cmp_data;
    logic        arm;
    logic        disarm;
    logic        irq_ack;
`ifdef TIMER_CMP_AUTO_REARM_EN
    logic [15:0] period_i;
`endif
    logic [15:0] timestamp;
    logic        irq;
    logic [1:0]  state_o;
    logic        ext_ovf;
    logic        seq_err;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] act;

    timer_compare dut (
        .clk       (clk),
        .rst       (rst),
        .count_i   (count_i),
        .overflow_i(overflow_i),
        .cmp_wr    (cmp_wr),
        .cmp_data  (cmp_data),
        .arm       (arm),
        .disarm    (disarm),
        .irq_ack   (irq_ack),
`ifdef TIMER_CMP_AUTO_REARM_EN
        .period_i  (period_i),
`endif
        .timestamp (timestamp),
        .irq       (irq),
        .state_o   (state_o),
        .ext_ovf   (ext_ovf),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            case (e.sel)
                SEL_TS:   act = 32'(timestamp);
                SEL_IRQ:  act = 32'(irq);
                SEL_ST:   act = 32'(state_o);
                SEL_EOVF: act = 32'(ext_ovf);
                default:  act = 32'(seq_err);
            endcase
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", e.nm, e.cyc, act, e.v);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        count_i    = count_i + 8'd1;
        overflow_i = (count_i == 8'hFF);
    endtask

    task automatic step();
        tick();
        adv();
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
        exp_t x;
        x.nm  = nm;
        x.sel = sel;
        x.v   = v;
        x.cyc = cyc;
        q.push_back(x);
    endtask

    task automatic do_reset(input logic [7:0] c);
        rst        = 1'b1;
        count_i    = c;
        overflow_i = (c == 8'hFF);
        cmp_wr     = 1'b0;
        cmp_data   = 16'h0;
        arm        = 1'b0;
        disarm     = 1'b0;
        irq_ack    = 1'b0;
`ifdef TIMER_CMP_AUTO_REARM_EN
        period_i   = 16'h0;
`endif
        tick();
        tick();
        expect_v(SEL_TS, {24'h0, c}, "rst_ts");
        expect_v(SEL_IRQ, 0, "rst_irq");
        expect_v(SEL_ST, 0, "rst_state");
        expect_v(SEL_EOVF, 0, "rst_ext_ovf");
        expect_v(SEL_SERR, 0, "rst_seq_err");
        rst = 1'b0;
    endtask

    initial begin
        // Free-run through the first overflow.
        do_reset(8'h00);
        repeat (255) step();
        expect_v(SEL_TS, 16'h00FF, "pre_ovf_ts");
        step();
        expect_v(SEL_TS, 16'h0100, "post_ovf_ts");
        expect_v(SEL_SERR, 0, "run_seq_err");

        // Write + arm together, fire at 0x0105, hold without ack, then ack.
        cmp_data = 16'h0105; cmp_wr = 1'b1; arm = 1'b1;
        step();
        cmp_wr = 1'b0; arm = 1'b0;
        expect_v(SEL_ST, 1, "armed_state");
        expect_v(SEL_TS, 16'h0101, "armed_ts");
        repeat (4) begin
            expect_v(SEL_IRQ, 0, "pre_match_irq");
            step();
        end
        expect_v(SEL_TS, 16'h0105, "match_ts");
        expect_v(SEL_IRQ, 0, "match_cycle_irq");
        step();
        expect_v(SEL_IRQ, 1, "fired_irq");
        expect_v(SEL_ST, 2, "fired_state");
        repeat (5) begin
            step();
            expect_v(SEL_IRQ, 1, "irq_hold");
        end
        irq_ack = 1'b1;
`ifdef TIMER_CMP_AUTO_REARM_EN
        disarm = 1'b1;
`endif
        step();
        irq_ack = 1'b0; disarm = 1'b0;
        expect_v(SEL_IRQ, 0, "ack_irq");
        expect_v(SEL_ST, 0, "ack_state");

        // Disarm exactly on the match cycle wins over the match.
        cmp_data = 16'h0203; cmp_wr = 1'b1; arm = 1'b1;
        step();
        cmp_wr = 1'b0; arm = 1'b0;
        expect_v(SEL_TS, 16'h010D, "arm2_ts");
        repeat (246) step();
        expect_v(SEL_TS, 16'h0203, "disarm_ts");
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        expect_v(SEL_ST, 0, "disarm_state");
        expect_v(SEL_IRQ, 0, "disarm_irq");
        repeat (3) step();
        expect_v(SEL_IRQ, 0, "disarm_irq_later");

        // FIRED ignores arm/disarm/cmp_wr; reset mid-FIRED drops irq.
        do_reset(8'h00);
        cmp_data = 16'h0003; cmp_wr = 1'b1; arm = 1'b1;
        step();
        cmp_wr = 1'b0; arm = 1'b0;
        step(); step();
        expect_v(SEL_TS, 16'h0003, "fr_match_ts");
        step();
        expect_v(SEL_IRQ, 1, "fr_irq");
        disarm = 1'b1; arm = 1'b1; cmp_wr = 1'b1; cmp_data = 16'h0000;
        step();
        disarm = 1'b0; arm = 1'b0; cmp_wr = 1'b0;
        expect_v(SEL_ST, 2, "fired_ignores_state");
        expect_v(SEL_IRQ, 1, "fired_ignores_irq");
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v(SEL_IRQ, 0, "midrst_irq");
        expect_v(SEL_ST, 0, "midrst_state");

`ifdef TIMER_CMP_AUTO_REARM_EN
        // Periodic re-arm: 0x0020 then 0x0030.
        do_reset(8'h00);
        period_i = 16'h0010; cmp_data = 16'h0020; cmp_wr = 1'b1; arm = 1'b1;
        step();
        cmp_wr = 1'b0; arm = 1'b0;
        repeat (31) step();
        expect_v(SEL_TS, 16'h0020, "ar_match1_ts");
        step();
        expect_v(SEL_IRQ, 1, "ar_irq1");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        expect_v(SEL_IRQ, 0, "ar_ack_irq");
        expect_v(SEL_ST, 1, "ar_rearmed_state");
        repeat (14) step();
        expect_v(SEL_TS, 16'h0030, "ar_match2_ts");
        expect_v(SEL_IRQ, 0, "ar_pre2_irq");
        step();
        expect_v(SEL_IRQ, 1, "ar_irq2");
        expect_v(SEL_ST, 2, "ar_fired2_state");
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v(SEL_IRQ, 0, "ar_rst_irq");
        expect_v(SEL_ST, 0, "ar_rst_state");
`endif

        // Legal steps: hold, +1, return to zero.
        do_reset(8'h10);
        tick();
        count_i = 8'h10; tick();
        count_i = 8'h11; tick();
        count_i = 8'h00; tick();
        count_i = 8'h01; tick();
        expect_v(SEL_SERR, 0, "seq_legal");
        count_i = 8'h03; tick();
        expect_v(SEL_SERR, 1, "seq_skip_err");

        // 0x10 -> 0x12 is a skip; the error stays after normal counting resumes.
        do_reset(8'h10);
        tick();
        count_i = 8'h12; tick();
        expect_v(SEL_SERR, 1, "seq_10_12_err");
        count_i = 8'h13; tick();
        count_i = 8'h14; tick();
        expect_v(SEL_SERR, 1, "seq_sticky");

        // Overflow asserted away from all-ones.
        do_reset(8'h7E);
        tick();
        expect_v(SEL_SERR, 0, "ovf_pre");
        count_i = 8'h7F; overflow_i = 1'b1; tick();
        overflow_i = 1'b0;
        expect_v(SEL_SERR, 1, "ovf_misplaced_err");

        // Full timestamp wrap.
        do_reset(8'h00);
        repeat (65535) step();
        expect_v(SEL_TS, 16'hFFFF, "wrap_pre_ts");
        expect_v(SEL_EOVF, 0, "wrap_pre_ext_ovf");
        step();
        expect_v(SEL_TS, 16'h0000, "wrap_ts");
        expect_v(SEL_EOVF, 1, "wrap_ext_ovf");
        expect_v(SEL_SERR, 0, "wrap_seq_err");

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
